mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the CPU instruction-fetch port (I, read-only) and the data port (D, read/write).
- Sits between the 5-stage pipeline core and the memory macro.
- Sequences accesses, picks which port wins on conflict, and raises per-port stall requests so the pipeline holds its registers until data returns.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MEM_LAT, 2, memory read latency in cycles from accepted request to rdata valid; legal range 1..7.
- STARVE_MAX, 4, consecutive D grants while I is waiting before I is forced to win.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  AW  fetch address.
- i_ack  out  1  one-cycle pulse; i_rdata valid this cycle.
- i_rdata  out  DW  fetched word.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  4  store byte enables.
- d_ack  out  1  one-cycle pulse; load data valid, or store completed.
- d_rdata  out  DW  load data.
- stall_if  out  1  i_req & ~i_ack (combinational).
- stall_mem  out  1  d_req & ~d_ack (combinational).
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  DW  valid MEM_LAT cycles after mem_en with mem_we = 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, latency counter = 0, starve counter = 0.
  - All outputs 0, except the stall outputs, which follow their inputs combinationally.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Any request: register the owner (I or D) and the owner's request fields, go to ISSUE.
- Arbitration in IDLE:
  - Only one request: that port wins.
  - Both requests: D wins, unless starve counter == STARVE_MAX, in which case I wins.
  - Starve counter increments on each D win while i_req = 1; clears on any I grant; saturates at STARVE_MAX.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we/addr/wdata/be driven from registered fields; for I owner, mem_we = 0 and mem_be = 4'hF.
  - Store: next state DONE.
  - Load or fetch: load latency counter with MEM_LAT-1, then WAIT if MEM_LAT > 1, else DONE.
- WAIT: decrement the counter each cycle; at 0, go to DONE.
- DONE (1 cycle):
  - Assert the owner's ack; rdata = mem_rdata sampled this cycle. For stores, d_rdata = 0.
  - Next state IDLE. Arbitration runs again in IDLE, so there is one idle cycle between accesses and no back-to-back bypass.
- Latency from req, with the arbiter idle and no contention:
  - Load or fetch: ack at cycle 2 + MEM_LAT (req at cycle 0).
  - Store: ack at cycle 2.
- Request fields are captured at grant. Later changes to addr/wdata by the requester are ignored until ack.
- A requester deasserting req before ack is a protocol error. The access still completes and the ack is still pulsed.
- Outputs are never glitched mid-access.
- i_ack and d_ack are never both 1 in the same cycle.
- Reset mid-access: the transaction is abandoned, no ack is issued, and mem_en is deasserted immediately.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, three 32-bit saturating counters are added, cleared on reset, and exposed as outputs:
  - perf_conflicts: cycles in IDLE with both requests present.
  - perf_i_wait: cycles with stall_if = 1.
  - perf_d_wait: cycles with stall_mem = 1.
- When undefined, the counter outputs and logic are absent; port list and behaviour are otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/DONE);
  - owner encoding OWN_I = 1'b0, OWN_D = 1'b1;
  - constant BE_FULL = 4'hF.
- One sub-module, arb_prio, is natural: the combinational priority select plus the starve counter register. The rest stays flat.

Test Plan:
- Single fetch, MEM_LAT = 2, i_addr = 0x100, memory word 0x00500093 → mem_en at cycle 1; i_ack at cycle 4 with i_rdata = 0x00500093; stall_if = 1 for cycles 0–3.
- Single store, d_addr = 0x40, d_wdata = 0xDEADBEEF, d_be = 4'b0011 → mem_en/mem_we at cycle 1 with be = 0011; d_ack at cycle 2; a subsequent load of 0x40 returns 0x0000BEEF on a zeroed memory.
- Simultaneous i_req and d_req at cycle 0 → D is served first with d_ack at cycle 4; I is issued after it with i_ack at cycle 9; never both acks in one cycle.
- d_req held continuously with i_req held, STARVE_MAX = 4 → after 4 D grants the 5th grant goes to I; starve counter reads 0 afterwards.
- rst pulsed low during WAIT of a load → no d_ack, mem_en = 0 immediately; the next request after release completes normally.
- With MEM_ARB_PERF_EN defined, the conflict scenario above → perf_conflicts = 1; perf_i_wait = 9; perf_d_wait = 4.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter (mem_arbiter).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic       OWN_I   = 1'b0;
    localparam logic       OWN_D   = 1'b1;
    localparam logic [3:0] BE_FULL = 4'hF;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
    localparam int LAT_W = 3;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// Fetch/data priority select for mem_arbiter: data wins on conflict until the
// fetch port has been passed over STARVE_MAX times in a row.
module arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic arb_en_i,
    output logic owner_o
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;
    logic          i_forced;

    always_comb begin
        i_forced = i_req_i && (starve_q == STARVE_LIM);
        owner_o  = (d_req_i && !i_forced) ? OWN_D : OWN_I;
        starve_d = starve_q;
        // Only D wins that leave a fetch waiting count towards starvation.
        if (arb_en_i && (i_req_i || d_req_i)) begin
            if (owner_o == OWN_I) begin
                starve_d = '0;
            end else if (i_req_i && (starve_q != STARVE_LIM)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between fetch (I) and
// data (D) ports. Optional performance counters: define MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_be,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_conflicts,
    output logic [31:0]   perf_i_wait,
    output logic [31:0]   perf_d_wait
`endif
);

    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             owner_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic [3:0]       be_q;
    logic             arb_owner;
    logic             grant;

    assign grant = (state_q == IDLE) && (i_req || d_req);

    arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk_i   (clk),
        .rst_ni  (rst),
        .i_req_i (i_req),
        .d_req_i (d_req),
        .arb_en_i(state_q == IDLE),
        .owner_o (arb_owner)
    );

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) state_d = ISSUE;
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    lat_d   = LAT_INIT;
                    state_d = (MEM_LAT > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (lat_q == '0) state_d = DONE;
                else             lat_d   = lat_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Request fields are frozen at grant; all outputs are gated by state, so
    // these need no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            owner_q <= arb_owner;
            if (arb_owner == OWN_D) begin
                we_q    <= d_we;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                be_q    <= d_be;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= i_addr;
                wdata_q <= '0;
                be_q    <= BE_FULL;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        if (state_q == ISSUE) begin
            mem_en    = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            mem_be    = be_q;
        end
        if (state_q == DONE) begin
            if (owner_q == OWN_I) begin
                i_ack   = 1'b1;
                i_rdata = mem_rdata;
            end else begin
                d_ack   = 1'b1;
                d_rdata = we_q ? '0 : mem_rdata;
            end
        end
    end

    assign stall_if  = i_req & ~i_ack;
    assign stall_mem = d_req & ~d_ack;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conf_q, perf_iw_q, perf_dw_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conf_q <= '0;
            perf_iw_q   <= '0;
            perf_dw_q   <= '0;
        end else begin
            perf_conf_q <= sat_inc32(perf_conf_q, (state_q == IDLE) && i_req && d_req);
            perf_iw_q   <= sat_inc32(perf_iw_q, stall_if);
            perf_dw_q   <= sat_inc32(perf_dw_q, stall_mem);
        end
    end

    assign perf_conflicts = perf_conf_q;
    assign perf_i_wait    = perf_iw_q;
    assign perf_d_wait    = perf_dw_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// conflict/starvation/reset sequences and a randomized run against a timeline model.
module tb_mem_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          i_ack, d_ack, stall_if, stall_mem;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_conflicts, perf_i_wait, perf_d_wait;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        , .perf_conflicts(perf_conflicts), .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
`endif
    );

    // Memory macro: writes at the strobe, read data appears MEM_LAT cycles
    // after the strobe and is held until the next read.
    logic [31:0] mem [0:255] = '{default: '0};
    logic [31:0] rd_pend = '0;
    int          rd_cnt = 0;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_en && !mem_we) begin
            if (MEM_LAT == 1) mem_rdata <= mem[mem_addr[9:2]];
            else begin
                rd_pend <= mem[mem_addr[9:2]];
                rd_cnt  <= MEM_LAT - 1;
            end
        end else if (rd_cnt > 0) begin
            if (rd_cnt == 1) mem_rdata <= rd_pend;
            rd_cnt <= rd_cnt - 1;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int id);
        int          lat_seen = -1;
        int          en_seen = -1;
        int          stall_cnt = 0;
        logic [31:0] rd = '0;
        logic [31:0] a_seen = '0;
        logic        we_seen = 1'b0;
        logic [3:0]  be_seen = '0;
        logic        wrong = 1'b0;
        @(posedge clk); #1;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int n = 0; n < 20 && lat_seen < 0; n++) begin
            @(negedge clk);
            if (mem_en) begin
                en_seen = n; we_seen = mem_we; be_seen = mem_be; a_seen = mem_addr;
            end
            if (v.is_d ? i_ack : d_ack) wrong = 1'b1;
            if (v.is_d ? stall_mem : stall_if) stall_cnt++;
            if (v.is_d ? d_ack : i_ack) begin
                lat_seen = n;
                rd = v.is_d ? d_rdata : i_rdata;
            end
            if (n == 1) begin
                d_addr = ~v.addr; d_wdata = ~v.wdata; i_addr = ~v.addr;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        chk($sformatf("v%0d_ack_cycle", id), lat_seen, v.exp_lat);
        chk($sformatf("v%0d_en_cycle", id), en_seen, 1);
        chk($sformatf("v%0d_mem_addr", id), a_seen, v.addr);
        chk($sformatf("v%0d_mem_we", id), we_seen, v.is_d & v.we);
        chk($sformatf("v%0d_mem_be", id), be_seen, v.is_d ? v.be : 4'hF);
        chk($sformatf("v%0d_rdata", id), rd, v.exp_rdata);
        chk($sformatf("v%0d_stall_cycles", id), stall_cnt, v.exp_lat);
        chk($sformatf("v%0d_other_ack", id), wrong, 1'b0);
    endtask

    task automatic reset_mid(input int at_cyc);
        logic saw_ack = 1'b0;
        logic en_before = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        for (int n = 0; n <= at_cyc; n++) begin
            @(negedge clk);
            if (d_ack) saw_ack = 1'b1;
        end
        en_before = mem_en;
        rst = 1'b0;
        #1;
        chk($sformatf("rst%0d_mem_en", at_cyc), mem_en, 1'b0);
        chk($sformatf("rst%0d_mem_addr", at_cyc), mem_addr, 32'h0);
        chk($sformatf("rst%0d_d_ack", at_cyc), d_ack, 1'b0);
        d_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (d_ack) saw_ack = 1'b1;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (d_ack) saw_ack = 1'b1;
        end
        chk($sformatf("rst%0d_en_before", at_cyc), en_before, at_cyc == 1);
        chk($sformatf("rst%0d_no_ack", at_cyc), saw_ack, 1'b0);
    endtask

    // Randomized-run reference state
    logic [31:0] shadow [0:255] = '{default: '0};
    logic        busy, own_d, e_we, e_iack, e_dack, e_en, prev_iack, prev_dack;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    int          free_cyc, gnt_cyc, ack_cyc, starve;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          iack_at, dack_at, nacks;
        logic        both;
        logic [31:0] ird, drd;
        logic [9:0]  seq;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] pc0, pi0, pd0, pc1, pi1, pd1;
`endif
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 32'h0050_0093, 4};
        vecs[1] = '{1'b1, 1'b1, 32'h040, 32'hDEAD_BEEF, 4'h3, 32'h0,         2};
        vecs[2] = '{1'b1, 1'b0, 32'h040, 32'h0,        4'hF, 32'h0000_BEEF, 4};
        vecs[3] = '{1'b1, 1'b1, 32'h080, 32'h1234_5678, 4'hF, 32'h0,         2};
        vecs[4] = '{1'b0, 1'b0, 32'h080, 32'h0,        4'hF, 32'h1234_5678, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h080, 32'hAABB_CCDD, 4'hC, 32'h0,         2};
        vecs[6] = '{1'b1, 1'b0, 32'h080, 32'h0,        4'hF, 32'hAABB_5678, 4};

        rst = 1'b0; i_req = 1'b1; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        @(posedge clk); #1;
        bd_we = 1'b1; bd_idx = 8'd64; bd_data = 32'h0050_0093;
        @(posedge clk); #1;
        bd_we = 1'b0;
        @(negedge clk);
        chk("rst_i_ack", i_ack, 1'b0);
        chk("rst_d_ack", d_ack, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", mem_be, 4'h0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_stall_if_hi", stall_if, 1'b1);
        chk("rst_stall_mem", stall_mem, 1'b0);
        i_req = 1'b0;
        #1;
        chk("rst_stall_if_lo", stall_if, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

        // Simultaneous fetch and load: D first, then I after one idle cycle.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        iack_at = -1; dack_at = -1; both = 1'b0; ird = '0; drd = '0;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
`ifdef MEM_ARB_PERF_EN
            if (n == 0) begin pc0 = perf_conflicts; pi0 = perf_i_wait; pd0 = perf_d_wait; end
            if (n == 10) begin pc1 = perf_conflicts; pi1 = perf_i_wait; pd1 = perf_d_wait; end
`endif
            if (i_ack && d_ack) both = 1'b1;
            if (d_ack && dack_at < 0) begin dack_at = n; drd = d_rdata; end
            if (i_ack && iack_at < 0) begin iack_at = n; ird = i_rdata; end
            @(posedge clk); #1;
            if (dack_at >= 0) d_req = 1'b0;
            if (iack_at >= 0) i_req = 1'b0;
        end
        chk("conf_d_ack_cycle", dack_at, 4);
        chk("conf_d_rdata", drd, 32'h0000_BEEF);
        chk("conf_i_ack_cycle", iack_at, 9);
        chk("conf_i_rdata", ird, 32'h0050_0093);
        chk("conf_both_acks", both, 1'b0);
`ifdef MEM_ARB_PERF_EN
        chk("perf_conflicts", pc1 - pc0, 32'd1);
        chk("perf_i_wait", pi1 - pi0, 32'd9);
        chk("perf_d_wait", pd1 - pd0, 32'd4);
`endif

        // Both ports held: four D grants, then a forced I grant, and again.
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        nacks = 0; seq = '0; both = 1'b0;
        for (int n = 0; n < 300 && nacks < 10; n++) begin
            @(negedge clk);
            if (i_ack && d_ack) both = 1'b1;
            if (i_ack || d_ack) begin
                seq = {seq[8:0], d_ack};
                nacks++;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        chk("starve_ack_count", nacks, 10);
        chk("starve_order", seq, 10'b1111011110);
        chk("starve_both_acks", both, 1'b0);

        reset_mid(1);
        reset_mid(3);
        run_vec(vecs[2], 7);

        // Randomized run against the timeline model.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        busy = 1'b0; free_cyc = 0; gnt_cyc = -10; ack_cyc = -10; starve = 0;
        prev_iack = 1'b0; prev_dack = 1'b0; own_d = 1'b0;
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_data = '0; e_be = '0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (prev_iack) i_req = 1'b0;
            if (prev_dack) d_req = 1'b0;
            if (!i_req && $urandom_range(0, 2) == 0) i_req = 1'b1;
            if (!d_req && $urandom_range(0, 2) == 0) d_req = 1'b1;
            if (i_req) i_addr = 32'h200 + 32'($urandom_range(0, 127)) * 32'd4;
            if (d_req) begin
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'h200 + 32'($urandom_range(0, 127)) * 32'd4;
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            e_iack = busy && !own_d && (c == ack_cyc);
            e_dack = busy && own_d && (c == ack_cyc);
            e_en   = busy && (c == gnt_cyc + 1);
            chk("rnd_i_ack", i_ack, e_iack);
            chk("rnd_d_ack", d_ack, e_dack);
            chk("rnd_stall_if", stall_if, i_req & ~e_iack);
            chk("rnd_stall_mem", stall_mem, d_req & ~e_dack);
            chk("rnd_mem_en", mem_en, e_en);
            if (e_en) begin
                chk("rnd_mem_addr", mem_addr, e_addr);
                chk("rnd_mem_we", mem_we, e_we);
                chk("rnd_mem_be", mem_be, e_be);
                if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
            end
            if (e_iack) chk("rnd_i_rdata", i_rdata, e_data);
            if (e_dack) chk("rnd_d_rdata", d_rdata, e_we ? 32'h0 : e_data);
            if (busy && c == ack_cyc) begin
                busy = 1'b0;
                free_cyc = c + 1;
            end
            if (!busy && c >= free_cyc && (i_req || d_req)) begin
                own_d = d_req && !(i_req && starve == STARVE_MAX);
                if (!own_d) starve = 0;
                else if (i_req && starve < STARVE_MAX) starve++;
                if (own_d) begin
                    e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
                end else begin
                    e_we = 1'b0; e_addr = i_addr; e_wdata = '0; e_be = 4'hF;
                end
                if (e_we) begin
                    for (int b = 0; b < 4; b++)
                        if (e_be[b]) shadow[e_addr[9:2]][8*b +: 8] = e_wdata[8*b +: 8];
                end else begin
                    e_data = shadow[e_addr[9:2]];
                end
                busy = 1'b1;
                gnt_cyc = c;
                ack_cyc = c + (e_we ? 2 : 2 + MEM_LAT);
            end
            prev_iack = i_ack;
            prev_dack = d_ack;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
